// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor
//   Bit-serial A - B, LSB first, one full-subtractor cell and a borrow flop,
//   with valid/ready handshakes on both sides. One operation in flight.
//   Revision: 1.0
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             busy
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_sd;
  logic               r_bw;
  logic               r_zero;
  logic [c_CNT_W-1:0] r_cnt;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bw_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sd_next;

  // Full-subtractor cell on the current LSBs
  assign w_x       = r_sa[0];
  assign w_y       = r_sb[0];
  assign w_d       = w_x ^ w_y ^ r_bw;
  assign w_bw_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_bw);
  assign w_sd_next = {w_d, r_sd[WIDTH-1:1]};
  assign w_accept  = (r_state == c_IDLE) && in_valid;
  assign w_last    = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (in_valid)  w_state_next = c_SHIFT;
      c_SHIFT: if (w_last)    w_state_next = c_DONE;
      c_DONE:  if (out_ready) w_state_next = c_IDLE;
      default:                w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      c_IDLE:  in_ready  = 1'b1;
      c_SHIFT: busy      = 1'b1;
      c_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // The zero flag is latched on the final shift so it is held, not decoded, in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sd   <= '0;
      r_bw   <= 1'b0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_sa   <= a;
      r_sb   <= b;
      r_bw   <= 1'b0;
      r_zero <= 1'b0;
      r_cnt  <= '0;
    end else if (r_state == c_SHIFT) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sd  <= w_sd_next;
      r_bw  <= w_bw_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_zero <= (w_sd_next == '0);
      end
    end
  end

  assign diff   = r_sd;
  assign borrow = r_bw;
  assign zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor
//   Bench for serial_subtractor at WIDTH 8, 2 and 32: cycle model + directed.
//   Revision: 1.0
// ============================================================================
module tb_serial_subtractor;

  localparam int NW = 3;

  function automatic int width_of(input int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic        s_rst       [NW];
  logic        s_in_valid  [NW];
  logic [31:0] s_a         [NW];
  logic [31:0] s_b         [NW];
  logic        s_out_ready [NW];
  logic        s_in_ready  [NW];
  logic        s_out_valid [NW];
  logic        s_busy      [NW];
  logic        s_borrow    [NW];
  logic        s_zero      [NW];
  logic [31:0] s_diff      [NW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NW; gi++) begin : g_w
    localparam int W = width_of(gi);
    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - W);

    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_borrow;
    logic         w_zero;
    logic         w_busy;
    logic [W-1:0] w_diff;

    serial_subtractor #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst      (s_rst[gi]),
      .in_valid (s_in_valid[gi]),
      .in_ready (w_in_ready),
      .a        (s_a[gi][W-1:0]),
      .b        (s_b[gi][W-1:0]),
      .out_valid(w_out_valid),
      .out_ready(s_out_ready[gi]),
      .diff     (w_diff),
      .borrow   (w_borrow),
      .zero     (w_zero),
      .busy     (w_busy)
    );

    assign s_in_ready[gi]  = w_in_ready;
    assign s_out_valid[gi] = w_out_valid;
    assign s_busy[gi]      = w_busy;
    assign s_borrow[gi]    = w_borrow;
    assign s_zero[gi]      = w_zero;
    assign s_diff[gi]      = 32'(w_diff);

    // Protocol model: phase 0 waiting, 1 computing for W cycles, 2 holding result
    int          m_ph     = 0;
    int          m_cnt    = 0;
    logic [31:0] m_diff   = '0;
    logic        m_borrow = 1'b0;
    logic        m_fresh  = 1'b0;
    logic        m_live   = 1'b0;

    always @(posedge clk) begin
      if (s_rst[gi]) begin
        m_ph    <= 0;
        m_fresh <= 1'b1;
        m_live  <= 1'b1;
      end else if (m_live) begin
        case (m_ph)
          0: if (s_in_valid[gi]) begin
               m_ph     <= 1;
               m_cnt    <= W;
               m_fresh  <= 1'b0;
               m_diff   <= ((s_a[gi] & MASK) - (s_b[gi] & MASK)) & MASK;
               m_borrow <= (s_a[gi] & MASK) < (s_b[gi] & MASK);
             end
          1: begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) m_ph <= 2;
             end
          default: if (s_out_ready[gi]) m_ph <= 0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (m_live) begin
        chk($sformatf("w%0d in_ready", W), 32'(w_in_ready), 32'(m_ph == 0));
        chk($sformatf("w%0d busy", W), 32'(w_busy), 32'(m_ph == 1));
        chk($sformatf("w%0d out_valid", W), 32'(w_out_valid), 32'(m_ph == 2));
        if (m_ph == 2) begin
          chk($sformatf("w%0d diff", W), 32'(w_diff), m_diff);
          chk($sformatf("w%0d borrow", W), 32'(w_borrow), 32'(m_borrow));
          chk($sformatf("w%0d zero", W), 32'(w_zero), 32'(m_diff == 0));
        end
        if (m_fresh) begin
          chk($sformatf("w%0d reset diff", W), 32'(w_diff), 32'h0);
          chk($sformatf("w%0d reset borrow", W), 32'(w_borrow), 32'h0);
          chk($sformatf("w%0d reset zero", W), 32'(w_zero), 32'h0);
        end
      end
    end
  end

  // Submits one WIDTH=8 operation with out_ready high and checks hand-computed results
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed,
                     input logic eb, input logic ez, input string nm);
    int k;
    s_a[0] = 32'(ta);
    s_b[0] = 32'(tb);
    s_out_ready[0] = 1'b1;
    k = 0;
    while (!s_in_ready[0] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({nm, " ready before accept"}, 32'(s_in_ready[0]), 32'h1);
    s_in_valid[0] = 1'b1;
    @(posedge clk); #1;
    s_in_valid[0] = 1'b0;
    k = 0;
    while (!s_out_valid[0] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({nm, " latency"}, 32'(k), 32'd8);
    chk({nm, " diff"}, s_diff[0], 32'(ed));
    chk({nm, " borrow"}, 32'(s_borrow[0]), 32'(eb));
    chk({nm, " zero"}, 32'(s_zero[0]), 32'(ez));
    @(posedge clk); #1;
    chk({nm, " in_ready after done"}, 32'(s_in_ready[0]), 32'h1);
    chk({nm, " out_valid after done"}, 32'(s_out_valid[0]), 32'h0);
  endtask

  task automatic rand_run(input int idx, input int n);
    int          sent;
    int          got;
    int          cyc;
    logic        acc;
    logic        del;
    logic [31:0] mask;
    sent = 0;
    got  = 0;
    cyc  = 0;
    mask = 32'hFFFF_FFFF >> (32 - width_of(idx));
    s_a[idx] = $urandom & mask;
    s_b[idx] = $urandom & mask;
    while ((sent < n || got < n) && cyc < n * 80) begin
      s_out_ready[idx] = 1'($urandom_range(0, 1));
      s_in_valid[idx]  = (sent < n);
      acc = s_in_valid[idx] && s_in_ready[idx];
      del = s_out_valid[idx] && s_out_ready[idx];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        s_a[idx] = $urandom & mask;
        s_b[idx] = $urandom & mask;
      end
      if (del) got++;
    end
    chk($sformatf("w%0d results delivered", width_of(idx)), 32'(got), 32'(n));
    s_in_valid[idx]  = 1'b0;
    s_out_ready[idx] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < NW; i++) begin
      s_rst[i]       = 1'b1;
      s_in_valid[i]  = 1'b0;
      s_out_ready[i] = 1'b0;
      s_a[i]         = '0;
      s_b[i]         = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NW; i++) s_rst[i] = 1'b0;

    chk("reset in_ready", 32'(s_in_ready[0]), 32'h1);
    chk("reset out_valid", 32'(s_out_valid[0]), 32'h0);
    chk("reset busy", 32'(s_busy[0]), 32'h0);
    chk("reset diff", s_diff[0], 32'h0);
    chk("reset borrow", 32'(s_borrow[0]), 32'h0);
    chk("reset zero", 32'(s_zero[0]), 32'h0);

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "5-3");
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "3-5");
    op8(8'h80, 8'hFF, 8'h81, 1'b1, 1'b0, "80-FF");
    op8(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, "FF-1");
    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, "0-0");
    op8(8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, "5A-5A");

    // Back-pressure: result must hold for 5 stalled cycles, then transfer exactly once
    s_a[0] = 32'h37;
    s_b[0] = 32'h12;
    s_out_ready[0] = 1'b0;
    s_in_valid[0]  = 1'b1;
    @(posedge clk); #1;
    s_in_valid[0] = 1'b0;
    k = 0;
    while (!s_out_valid[0] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("bp latency", 32'(k), 32'd8);
    for (int i = 0; i < 5; i++) begin
      chk("bp diff held", s_diff[0], 32'h25);
      chk("bp borrow held", 32'(s_borrow[0]), 32'h0);
      chk("bp zero held", 32'(s_zero[0]), 32'h0);
      chk("bp out_valid held", 32'(s_out_valid[0]), 32'h1);
      chk("bp in_ready low", 32'(s_in_ready[0]), 32'h0);
      @(posedge clk); #1;
    end
    s_out_ready[0] = 1'b1;
    @(posedge clk); #1;
    s_out_ready[0] = 1'b0;
    chk("bp released out_valid", 32'(s_out_valid[0]), 32'h0);
    chk("bp released in_ready", 32'(s_in_ready[0]), 32'h1);
    @(posedge clk); #1;
    chk("bp single transfer", 32'(s_out_valid[0]), 32'h0);

    // Reset during the 4th shift cycle aborts the operation
    s_a[0] = 32'h33;
    s_b[0] = 32'h11;
    s_out_ready[0] = 1'b1;
    s_in_valid[0]  = 1'b1;
    @(posedge clk); #1;
    s_in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid-op busy", 32'(s_busy[0]), 32'h1);
    s_rst[0] = 1'b1;
    @(posedge clk); #1;
    s_rst[0] = 1'b0;
    chk("abort in_ready", 32'(s_in_ready[0]), 32'h1);
    chk("abort out_valid", 32'(s_out_valid[0]), 32'h0);
    chk("abort busy", 32'(s_busy[0]), 32'h0);
    chk("abort diff", s_diff[0], 32'h0);
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "10-1 after abort");

    fork
      rand_run(0, 200);
      rand_run(1, 200);
      rand_run(2, 200);
    join

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
